// File: rtl/pe_wei_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : pe_wei_loader_if
// Description : Bundles the upstream weight stream (valid/ready) and the
//               per-PE FIFO write port (push/push_id/data_in/full).
//               The master side is the loader; the slave side is the
//               environment (global weight buffer plus multi-read FIFO).
// Revision    : 1.0 - initial release
// ============================================================================
interface pe_wei_loader_if #(
    parameter int DATA_WIDTH = 64,
    parameter int RD_NUM     = 27,
    parameter int ID_WIDTH   = $clog2(RD_NUM)
);
    // Upstream stream from the global weight buffer
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;

    // Downstream per-PE FIFO write port
    logic [RD_NUM-1:0]     full;
    logic                  push;
    logic [ID_WIDTH-1:0]   push_id;
    logic [DATA_WIDTH-1:0] data_in;

    modport master (
        input  in_valid, in_data, full,
        output in_ready, push, push_id, data_in
    );

    modport slave (
        output in_valid, in_data, full,
        input  in_ready, push, push_id, data_in
    );
endinterface
`default_nettype wire

// File: rtl/pe_wei_loader.sv
`default_nettype none
// ============================================================================
// Module      : pe_wei_loader
// Description : Steers an ordered stream of weight words into per-PE queues.
//               Each round gives every active id a block of contiguous
//               words; the pattern repeats for the configured round count.
//               Stalls (never skips) while the current target id is full.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_wei_loader #(
    parameter int DATA_WIDTH  = 64,
    parameter int RD_NUM      = 27,
    parameter int ID_WIDTH    = $clog2(RD_NUM),
    parameter int WORD_WIDTH  = 8,
    parameter int ROUND_WIDTH = 8
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   Reset,
    input  wire logic                   start,
    input  wire logic [ID_WIDTH:0]      cfg_num_id,
    input  wire logic [WORD_WIDTH-1:0]  cfg_words,
    input  wire logic [ROUND_WIDTH-1:0] cfg_rounds,
    output logic                        busy,
    output logic                        done,
    pe_wei_loader_if.master             bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ID_WIDTH:0] c_rd_num = (ID_WIDTH+1)'(RD_NUM);

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [ID_WIDTH-1:0]    r_id_cnt;
    logic [WORD_WIDTH-1:0]  r_word_cnt;
    logic [ROUND_WIDTH-1:0] r_round_cnt;

    logic [ID_WIDTH:0]      r_num_id;
    logic [WORD_WIDTH-1:0]  r_words;
    logic [ROUND_WIDTH-1:0] r_rounds;

    logic [ID_WIDTH:0]      w_num_id_clamped;
    logic                   w_cfg_zero;
    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_last_word;
    logic                   w_last_id;
    logic                   w_last_round;

    // Ids beyond the physical port count would address non-existent queues
    assign w_num_id_clamped = (cfg_num_id > c_rd_num) ? c_rd_num : cfg_num_id;
    assign w_cfg_zero       = (cfg_num_id == '0) || (cfg_words == '0) || (cfg_rounds == '0);

    // Full is looked at in the same cycle; the FIFO raises it before the next push
    assign w_in_ready   = (r_state == S_LOAD) && !bus.full[r_id_cnt];
    assign w_accept     = bus.in_valid && w_in_ready;

    assign w_last_word  = (r_word_cnt  == r_words  - WORD_WIDTH'(1));
    assign w_last_id    = ({1'b0, r_id_cnt} == r_num_id - (ID_WIDTH+1)'(1));
    assign w_last_round = (r_round_cnt == r_rounds - ROUND_WIDTH'(1));

    assign bus.in_ready = w_in_ready;
    assign bus.push     = w_accept;
    assign bus.push_id  = r_id_cnt;
    assign bus.data_in  = bus.in_data;

    // State register; the synchronous clear overrides any pending start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and status outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_cfg_zero ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                busy = 1'b1;
                if (w_accept && w_last_word && w_last_id && w_last_round) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Config latch and word/id/round position counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_cnt    <= '0;
            r_word_cnt  <= '0;
            r_round_cnt <= '0;
            r_num_id    <= '0;
            r_words     <= '0;
            r_rounds    <= '0;
        end else if (Reset) begin
            r_id_cnt    <= '0;
            r_word_cnt  <= '0;
            r_round_cnt <= '0;
            r_num_id    <= '0;
            r_words     <= '0;
            r_rounds    <= '0;
        end else if (r_state == S_IDLE) begin
            r_id_cnt    <= '0;
            r_word_cnt  <= '0;
            r_round_cnt <= '0;
            if (start) begin
                r_num_id <= w_num_id_clamped;
                r_words  <= cfg_words;
                r_rounds <= cfg_rounds;
            end
        end else if (w_accept) begin
            if (w_last_word) begin
                r_word_cnt <= '0;
                if (w_last_id) begin
                    r_id_cnt    <= '0;
                    r_round_cnt <= w_last_round ? '0 : r_round_cnt + ROUND_WIDTH'(1);
                end else begin
                    r_id_cnt <= r_id_cnt + ID_WIDTH'(1);
                end
            end else begin
                r_word_cnt <= r_word_cnt + WORD_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_wei_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_wei_loader
// Description : Directed self-checking bench for pe_wei_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_wei_loader;

    localparam int DATA_WIDTH  = 64;
    localparam int RD_NUM      = 27;
    localparam int ID_WIDTH    = $clog2(RD_NUM);
    localparam int WORD_WIDTH  = 8;
    localparam int ROUND_WIDTH = 8;

    logic                   clk;
    logic                   rst_n;
    logic                   Reset;
    logic                   start;
    logic [ID_WIDTH:0]      cfg_num_id;
    logic [WORD_WIDTH-1:0]  cfg_words;
    logic [ROUND_WIDTH-1:0] cfg_rounds;
    logic                   busy;
    logic                   done;

    int n_checks = 0;
    int n_errors = 0;

    pe_wei_loader_if #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_NUM     (RD_NUM),
        .ID_WIDTH   (ID_WIDTH)
    ) bus ();

    pe_wei_loader #(
        .DATA_WIDTH  (DATA_WIDTH),
        .RD_NUM      (RD_NUM),
        .ID_WIDTH    (ID_WIDTH),
        .WORD_WIDTH  (WORD_WIDTH),
        .ROUND_WIDTH (ROUND_WIDTH)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Reset      (Reset),
        .start      (start),
        .cfg_num_id (cfg_num_id),
        .cfg_words  (cfg_words),
        .cfg_rounds (cfg_rounds),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [ID_WIDTH:0] n, input logic [7:0] w, input logic [7:0] r);
        start      = 1'b1;
        cfg_num_id = n;
        cfg_words  = w;
        cfg_rounds = r;
        tick();
        start      = 1'b0;
        cfg_num_id = '0;
        cfg_words  = '0;
        cfg_rounds = '0;
    endtask

    int ids_basic [6] = '{0, 0, 1, 1, 2, 2};
    int bp_push   [10] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
    int bp_id     [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 2, 2};
    int gap_ids   [6] = '{0, 1, 0, 1, 0, 1};

    initial begin
        int d;
        int np;
        rst_n        = 1'b0;
        Reset        = 1'b0;
        start        = 1'b0;
        cfg_num_id   = '0;
        cfg_words    = '0;
        cfg_rounds   = '0;
        bus.in_valid = 1'b1;
        bus.in_data  = 64'hdead;
        bus.full     = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- reset state ----------------
        @(negedge clk);
        check("rst_busy",     64'(busy),         64'd0);
        check("rst_done",     64'(done),         64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_push",     64'(bus.push),     64'd0);
        check("rst_push_id",  64'(bus.push_id),  64'd0);
        tick();

        // ---------------- basic ordering ----------------
        bus.in_data = 64'h10;
        start = 1'b1; cfg_num_id = 6'd3; cfg_words = 8'd2; cfg_rounds = 8'd1;
        @(negedge clk);
        check("basic_idle_ready", 64'(bus.in_ready), 64'd0);
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.in_data = 64'h10 + 64'(k);
            @(negedge clk);
            check("basic_push",  64'(bus.push),    64'd1);
            check("basic_id",    64'(bus.push_id), 64'(ids_basic[k]));
            check("basic_data",  bus.data_in,      64'h10 + 64'(k));
            check("basic_busy",  64'(busy),        64'd1);
            tick();
        end
        @(negedge clk);
        check("basic_done",      64'(done),     64'd1);
        check("basic_busy_end",  64'(busy),     64'd0);
        check("basic_push_end",  64'(bus.push), 64'd0);
        tick();
        @(negedge clk);
        check("basic_done_clr",  64'(done),     64'd0);
        tick();

        // ---------------- back-pressure ----------------
        kick(6'd3, 8'd2, 8'd1);
        d = 0;
        for (int k = 0; k < 10; k++) begin
            bus.full    = (k >= 2 && k < 6) ? 27'b10 : 27'b0;
            bus.in_data = 64'h20 + 64'(d);
            @(negedge clk);
            check("bp_push",  64'(bus.push),     64'(bp_push[k]));
            check("bp_ready", 64'(bus.in_ready), 64'(bp_push[k]));
            check("bp_id",    64'(bus.push_id),  64'(bp_id[k]));
            if (bp_push[k] == 1) begin
                check("bp_data", bus.data_in, 64'h20 + 64'(d));
            end
            check("bp_done_early", 64'(done), 64'd0);
            tick();
            if (bp_push[k] == 1) d++;
        end
        bus.full = '0;
        @(negedge clk);
        check("bp_done", 64'(done), 64'd1);
        tick();

        // ---------------- upstream gaps, several rounds ----------------
        kick(6'd2, 8'd1, 8'd3);
        np = 0;
        for (int k = 0; k < 11; k++) begin
            bus.in_valid = (k % 2 == 0);
            bus.in_data  = 64'h50 + 64'(np);
            @(negedge clk);
            check("gap_push",  64'(bus.push),     64'(k % 2 == 0));
            check("gap_ready", 64'(bus.in_ready), 64'd1);
            if (bus.push && np < 6) begin
                check("gap_id",   64'(bus.push_id), 64'(gap_ids[np]));
                check("gap_data", bus.data_in,      64'h50 + 64'(np));
            end
            check("gap_done_early", 64'(done), 64'd0);
            if (bus.push) np++;
            tick();
        end
        bus.in_valid = 1'b1;
        check("gap_count", 64'(np), 64'd6);
        @(negedge clk);
        check("gap_done", 64'(done), 64'd1);
        tick();
        @(negedge clk);
        check("gap_done_once", 64'(done), 64'd0);
        tick();

        // ---------------- num_id clamp ----------------
        kick(6'd31, 8'd1, 8'd1);
        for (int k = 0; k < 27; k++) begin
            @(negedge clk);
            check("clamp_push", 64'(bus.push),    64'd1);
            check("clamp_id",   64'(bus.push_id), 64'(k));
            tick();
        end
        @(negedge clk);
        check("clamp_done", 64'(done), 64'd1);
        tick();

        // ---------------- zero words ----------------
        kick(6'd3, 8'd0, 8'd2);
        @(negedge clk);
        check("zero_done",  64'(done),         64'd1);
        check("zero_ready", 64'(bus.in_ready), 64'd0);
        check("zero_push",  64'(bus.push),     64'd0);
        tick();
        @(negedge clk);
        check("zero_done_clr", 64'(done),         64'd0);
        check("zero_ready2",   64'(bus.in_ready), 64'd0);
        tick();

        // ---------------- reset mid-load, reset beats start ----------------
        kick(6'd3, 8'd2, 8'd1);
        for (int k = 0; k < 3; k++) begin
            bus.in_data = 64'h30 + 64'(k);
            if (k == 2) Reset = 1'b1;
            @(negedge clk);
            check("rst_mid_push", 64'(bus.push), 64'd1);
            tick();
        end
        start = 1'b1; cfg_num_id = 6'd3; cfg_words = 8'd2; cfg_rounds = 8'd1;
        @(negedge clk);
        check("rst_mid_busy",  64'(busy),         64'd0);
        check("rst_mid_done",  64'(done),         64'd0);
        check("rst_mid_ready", 64'(bus.in_ready), 64'd0);
        tick();
        Reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_win_busy", 64'(busy), 64'd0);
        check("rst_win_done", 64'(done), 64'd0);
        tick();

        // Restart; a start pulse mid-load must not disturb the sequence
        kick(6'd3, 8'd2, 8'd1);
        for (int k = 0; k < 6; k++) begin
            bus.in_data = 64'h40 + 64'(k);
            if (k == 1) begin
                start = 1'b1; cfg_num_id = 6'd1; cfg_words = 8'd1; cfg_rounds = 8'd1;
            end else begin
                start = 1'b0; cfg_num_id = '0; cfg_words = '0; cfg_rounds = '0;
            end
            @(negedge clk);
            check("restart_push", 64'(bus.push),    64'd1);
            check("restart_id",   64'(bus.push_id), 64'(ids_basic[k]));
            check("restart_data", bus.data_in,      64'h40 + 64'(k));
            tick();
        end
        start = 1'b0;
        @(negedge clk);
        check("restart_done", 64'(done), 64'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
